// File: rtl/mu0_control.sv
// MU0 fetch/execute control FSM: sequences the datapath enables, ALU function and memory strobes.
// Optional memory wait-state handshake (Mem_Rdy) enabled by defining MU0_CONTROL_WAIT_EN.
module mu0_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
`ifdef MU0_CONTROL_WAIT_EN
    input  logic       Mem_Rdy,
`endif
    output logic       Addr_sel,
    output logic       X_sel,
    output logic       Y_sel,
    output logic [1:0] ALU_fs,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic       MEM_rd,
    output logic       MEM_wr,
    output logic       Halted
);

    localparam int unsigned ALU_FS_W = 2;

    localparam logic [ALU_FS_W-1:0] ALU_PASS_Y = 2'b00;
    localparam logic [ALU_FS_W-1:0] ALU_ADD    = 2'b01;
    localparam logic [ALU_FS_W-1:0] ALU_INC    = 2'b10;
    localparam logic [ALU_FS_W-1:0] ALU_SUB    = 2'b11;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        HALT    = 2'b10
    } state_t;

    typedef enum logic [3:0] {
        OP_LDA = 4'd0,
        OP_STA = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_JMP = 4'd4,
        OP_JGE = 4'd5,
        OP_JNE = 4'd6,
        OP_STP = 4'd7
    } opcode_t;

    state_t state;
    state_t next_state;
    logic   mem_ready;

`ifdef MU0_CONTROL_WAIT_EN
    assign mem_ready = Mem_Rdy;
`else
    assign mem_ready = 1'b1;
`endif

    // State register; synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state = FETCH;
        Addr_sel   = 1'b0;
        X_sel      = 1'b0;
        Y_sel      = 1'b0;
        ALU_fs     = ALU_PASS_Y;
        PC_En      = 1'b0;
        IR_En      = 1'b0;
        Acc_En     = 1'b0;
        MEM_rd     = 1'b0;
        MEM_wr     = 1'b0;
        Halted     = 1'b0;

        case (state)
            FETCH: begin
                Addr_sel   = 1'b0;
                MEM_rd     = 1'b1;
                X_sel      = 1'b1;
                ALU_fs     = ALU_INC;
                IR_En      = mem_ready;
                PC_En      = mem_ready;
                next_state = mem_ready ? EXECUTE : FETCH;
            end

            EXECUTE: begin
                case (F)
                    OP_LDA: begin
                        Addr_sel   = 1'b1;
                        MEM_rd     = 1'b1;
                        Y_sel      = 1'b0;
                        ALU_fs     = ALU_PASS_Y;
                        Acc_En     = mem_ready;
                        next_state = mem_ready ? FETCH : EXECUTE;
                    end
                    OP_STA: begin
                        Addr_sel   = 1'b1;
                        MEM_wr     = 1'b1;
                        next_state = mem_ready ? FETCH : EXECUTE;
                    end
                    OP_ADD, OP_SUB: begin
                        Addr_sel   = 1'b1;
                        MEM_rd     = 1'b1;
                        X_sel      = 1'b0;
                        Y_sel      = 1'b0;
                        ALU_fs     = (F == OP_ADD) ? ALU_ADD : ALU_SUB;
                        Acc_En     = mem_ready;
                        next_state = mem_ready ? FETCH : EXECUTE;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        // Branch target is IR[11:0] passed through the ALU; no memory access.
                        Y_sel  = 1'b1;
                        ALU_fs = ALU_PASS_Y;
                        case (F)
                            OP_JGE:  PC_En = ~N;
                            OP_JNE:  PC_En = ~Z;
                            default: PC_En = 1'b1;
                        endcase
                        next_state = FETCH;
                    end
                    OP_STP: begin
                        next_state = HALT;
                    end
                    default: begin
                        next_state = HALT_ON_ILLEGAL ? HALT : FETCH;
                    end
                endcase
            end

            HALT: begin
                Halted     = 1'b1;
                next_state = HALT;
            end

            default: begin
                next_state = FETCH;
            end
        endcase

        // Reset holds every control line inactive regardless of state.
        if (!Reset) begin
            next_state = FETCH;
            Addr_sel   = 1'b0;
            X_sel      = 1'b0;
            Y_sel      = 1'b0;
            ALU_fs     = ALU_PASS_Y;
            PC_En      = 1'b0;
            IR_En      = 1'b0;
            Acc_En     = 1'b0;
            MEM_rd     = 1'b0;
            MEM_wr     = 1'b0;
            Halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mu0_control.sv
// Scoreboard bench for mu0_control: two instances (illegal opcodes as no-op / as halt) against an instruction-level model.
module tb_mu0_control;

    logic       clk;
    logic       rst_n;
    logic [3:0] f;
    logic       n;
    logic       z;
    logic       mem_rdy;

    logic       as0, xs0, ys0, pc0, ir0, acc0, rd0, wr0, h0;
    logic [1:0] fs0;
    logic       as1, xs1, ys1, pc1, ir1, acc1, rd1, wr1, h1;
    logic [1:0] fs1;

`ifdef MU0_CONTROL_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    mu0_control #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .Clk(clk), .Reset(rst_n), .F(f), .N(n), .Z(z),
`ifdef MU0_CONTROL_WAIT_EN
        .Mem_Rdy(mem_rdy),
`endif
        .Addr_sel(as0), .X_sel(xs0), .Y_sel(ys0), .ALU_fs(fs0), .PC_En(pc0),
        .IR_En(ir0), .Acc_En(acc0), .MEM_rd(rd0), .MEM_wr(wr0), .Halted(h0)
    );

    mu0_control #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
        .Clk(clk), .Reset(rst_n), .F(f), .N(n), .Z(z),
`ifdef MU0_CONTROL_WAIT_EN
        .Mem_Rdy(mem_rdy),
`endif
        .Addr_sel(as1), .X_sel(xs1), .Y_sel(ys1), .ALU_fs(fs1), .PC_En(pc1),
        .IR_En(ir1), .Acc_En(acc1), .MEM_rd(rd1), .MEM_wr(wr1), .Halted(h1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {Addr_sel, X_sel, Y_sel, ALU_fs[1:0], PC_En, IR_En, Acc_En, MEM_rd, MEM_wr, Halted}
    typedef struct packed {
        logic [10:0] v0;
        logic [10:0] v1;
        logic [10:0] mask;
        logic [3:0]  op;
    } exp_t;

    localparam logic [10:0] MASK_ALL   = 11'h7FF;
    localparam logic [10:0] MASK_RESET = 11'b100_00_111111;

    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_HALT  = 2;

    exp_t sb[$];
    int   tests  = 0;
    int   errors = 0;
    int   ph0    = PH_FETCH;
    int   ph1    = PH_FETCH;

    // Expected control word from the instruction-level rules.
    function automatic logic [10:0] model_out(int ph, bit r, bit [3:0] op, bit nn, bit zz, bit rdy);
        bit       a_s, x_s, y_s, pce, ire, acce, rd, wr, hl;
        bit [1:0] fn;
        {a_s, x_s, y_s, pce, ire, acce, rd, wr, hl} = '0;
        fn = 2'd0;
        if (r) begin
            if (ph == PH_FETCH) begin
                rd = 1; x_s = 1; fn = 2'd2; ire = rdy; pce = rdy;
            end else if (ph == PH_EXEC) begin
                if (op == 4'd1) begin
                    a_s = 1; wr = 1;
                end else if (op == 4'd0 || op == 4'd2 || op == 4'd3) begin
                    a_s = 1; rd = 1; acce = rdy;
                    fn = (op == 4'd0) ? 2'd0 : (op == 4'd2) ? 2'd1 : 2'd3;
                end else if (op >= 4'd4 && op <= 4'd6) begin
                    y_s = 1;
                    pce = (op == 4'd4) ? 1'b1 : (op == 4'd5) ? !nn : !zz;
                end
            end else begin
                hl = 1;
            end
        end
        return {a_s, x_s, y_s, fn, pce, ire, acce, rd, wr, hl};
    endfunction

    function automatic int model_next(int ph, bit r, bit [3:0] op, bit rdy, bit hoi);
        if (!r) return PH_FETCH;
        if (ph == PH_HALT) return PH_HALT;
        if (ph == PH_FETCH) return rdy ? PH_EXEC : PH_FETCH;
        if (op <= 4'd3 && !rdy) return PH_EXEC;
        if (op == 4'd7) return PH_HALT;
        if (op >= 4'd8) return hoi ? PH_HALT : PH_FETCH;
        return PH_FETCH;
    endfunction

    // Drive one cycle of inputs after the active edge and queue what both DUTs should show.
    task automatic step(input bit r, input bit [3:0] op, input bit nn, input bit zz, input bit rdy);
        exp_t e;
        bit   eff_rdy;
        @(posedge clk);
        #1;
        eff_rdy = WAIT_EN ? rdy : 1'b1;
        rst_n   = r;
        f       = op;
        n       = nn;
        z       = zz;
        mem_rdy = eff_rdy;
        e.v0    = model_out(ph0, r, op, nn, zz, eff_rdy);
        e.v1    = model_out(ph1, r, op, nn, zz, eff_rdy);
        e.mask  = r ? MASK_ALL : MASK_RESET;
        e.op    = op;
        sb.push_back(e);
        ph0 = model_next(ph0, r, op, eff_rdy, 1'b0);
        ph1 = model_next(ph1, r, op, eff_rdy, 1'b1);
    endtask

    // Monitor: compare every presented cycle on the falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t        e;
            logic [10:0] a0, a1;
            e  = sb.pop_front();
            a0 = {as0, xs0, ys0, fs0, pc0, ir0, acc0, rd0, wr0, h0};
            a1 = {as1, xs1, ys1, fs1, pc1, ir1, acc1, rd1, wr1, h1};
            tests++;
            if ((a0 & e.mask) !== (e.v0 & e.mask)) begin
                errors++;
                $display("FAIL ctl_noop_illegal t=%0t F=%0d got=%b want=%b mask=%b", $time, e.op, a0, e.v0, e.mask);
            end
            tests++;
            if ((a1 & e.mask) !== (e.v1 & e.mask)) begin
                errors++;
                $display("FAIL ctl_halt_illegal t=%0t F=%0d got=%b want=%b mask=%b", $time, e.op, a1, e.v1, e.mask);
            end
        end
    end

    initial begin
        int budget;
        rst_n   = 1'b0;
        f       = 4'd0;
        n       = 1'b0;
        z       = 1'b0;
        mem_rdy = 1'b1;

        // Reset, then LDA.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // ADD, SUB, STA.
        step(1, 2, 0, 0, 1); step(1, 2, 0, 0, 1);
        step(1, 3, 0, 0, 1); step(1, 3, 0, 0, 1);
        step(1, 1, 0, 0, 1); step(1, 1, 0, 0, 1);
        // Conditional jumps on both flag values, then JMP.
        step(1, 5, 1, 0, 1); step(1, 5, 1, 0, 1);
        step(1, 5, 0, 0, 1); step(1, 5, 0, 0, 1);
        step(1, 6, 0, 1, 1); step(1, 6, 0, 1, 1);
        step(1, 6, 0, 0, 1); step(1, 6, 0, 0, 1);
        step(1, 4, 1, 1, 1); step(1, 4, 1, 1, 1);
        // STP, stay halted, then a single reset edge.
        step(1, 7, 0, 0, 1); step(1, 7, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // Illegal opcode: no-op on one instance, halt on the other.
        step(1, 9, 0, 0, 1); step(1, 9, 0, 0, 1);
        step(1, 2, 0, 0, 1); step(1, 2, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // Wait states during fetch and during a memory execute.
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 1);
        step(1, 5, 0, 0, 1); step(1, 5, 0, 0, 0);

        // Randomized run with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 24) != 0), 4'($urandom_range(0, 15)), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
